// File: rtl/clock_pkg.sv
// clock_pkg: FSM encoding, BCD field limits and the inc/dec step rule shared by the time-setting front end.
package clock_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOUR = 2'd1,
        MIN  = 2'd2
    } state_e;

    localparam logic [3:0] HOUR_MAX_T = 4'd2;
    localparam logic [3:0] HOUR_MAX_O = 4'd3;
    localparam logic [3:0] MIN_MAX_T  = 4'd5;
    localparam logic [3:0] MIN_MAX_O  = 4'd9;

    // A value outside 00..max (captured from a counter in a bad state) snaps to 00 on inc, max on dec.
    function automatic logic [7:0] bcd_step(
        input logic [3:0] t,
        input logic [3:0] o,
        input logic       up,
        input logic [3:0] mt,
        input logic [3:0] mo
    );
        logic bad;
        bad = (t > mt) || (t == mt && o > mo) || (o > 4'd9);
        if (up)
            return (bad || (t == mt && o == mo)) ? 8'h00 :
                   (o == 4'd9) ? {t + 4'd1, 4'd0} : {t, o + 4'd1};
        return (bad || (t == 4'd0 && o == 4'd0)) ? {mt, mo} :
               (o == 4'd0) ? {t - 4'd1, 4'd9} : {t, o - 4'd1};
    endfunction

endpackage

// File: rtl/time_set_ctrl_if.sv
// time_set_ctrl_if: set/readback bundle between the time-set front end and the hour/minute counters.
interface time_set_ctrl_if;

    logic       set_hour;
    logic       set_min;
    logic [3:0] set_num1;
    logic [3:0] set_num2;
    logic [3:0] cur_hour1;
    logic [3:0] cur_hour2;
    logic [3:0] cur_min1;
    logic [3:0] cur_min2;

    modport master (
        output set_hour, set_min, set_num1, set_num2,
        input  cur_hour1, cur_hour2, cur_min1, cur_min2
    );

    modport slave (
        input  set_hour, set_min, set_num1, set_num2,
        output cur_hour1, cur_hour2, cur_min1, cur_min2
    );

endinterface

// File: rtl/btn_debounce.sv
// btn_debounce: 2-FF synchronizer, consecutive-cycle debouncer and one-cycle press pulse on the debounced rise.
module btn_debounce #(
    parameter int DEB_COUNT = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_i,
    output logic pulse_o
);

    localparam int           W    = $clog2(DEB_COUNT + 1);
    localparam logic [W-1:0] LAST = W'(DEB_COUNT - 1);

    logic [1:0]   sync_q;
    logic [W-1:0] cnt_q, cnt_d;
    logic         lvl_q, lvl_d;
    logic         prev_q, pulse_q;
    logic         diff;

    always_comb begin
        diff  = sync_q[1] != lvl_q;
        cnt_d = (diff && cnt_q != LAST) ? cnt_q + 1'b1 : '0;
        lvl_d = (diff && cnt_q == LAST) ? sync_q[1] : lvl_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            lvl_q   <= 1'b0;
            prev_q  <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], btn_i};
            cnt_q   <= cnt_d;
            lvl_q   <= lvl_d;
            prev_q  <= lvl_q;
            pulse_q <= lvl_q & ~prev_q;
        end
    end

    assign pulse_o = pulse_q;

endmodule

// File: rtl/time_set_ctrl.sv
// time_set_ctrl: button-driven IDLE->HOUR->MIN mode FSM editing a BCD value for the counters' set interface.
module time_set_ctrl
    import clock_pkg::*;
#(
    parameter int DEB_COUNT = 1_000_000,
    parameter int BLINK_DIV = 25_000_000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            btn_mode,
    input  logic            btn_inc,
    input  logic            btn_dec,
    time_set_ctrl_if.master bus,
    output logic            blink
);

    localparam int            BW         = $clog2(BLINK_DIV + 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

    logic          mode_p, inc_p, dec_p;
    state_e        state_q, state_d;
    logic [3:0]    num1_q, num2_q, num1_d, num2_d;
    logic          set_hour_q, set_min_q;
    logic          blink_q, blink_d;
    logic [BW-1:0] bcnt_q, bcnt_d;
    logic [7:0]    step;

    btn_debounce #(.DEB_COUNT(DEB_COUNT)) u_mode (.clk(clk), .rst_n(rst_n), .btn_i(btn_mode), .pulse_o(mode_p));
    btn_debounce #(.DEB_COUNT(DEB_COUNT)) u_inc  (.clk(clk), .rst_n(rst_n), .btn_i(btn_inc),  .pulse_o(inc_p));
    btn_debounce #(.DEB_COUNT(DEB_COUNT)) u_dec  (.clk(clk), .rst_n(rst_n), .btn_i(btn_dec),  .pulse_o(dec_p));

    // Mode outranks inc/dec; opposing inc and dec in one cycle cancel.
    always_comb begin
        step = (state_q == HOUR) ? bcd_step(num1_q, num2_q, inc_p, HOUR_MAX_T, HOUR_MAX_O)
                                 : bcd_step(num1_q, num2_q, inc_p, MIN_MAX_T, MIN_MAX_O);
        state_d          = state_q;
        {num1_d, num2_d} = {num1_q, num2_q};
        if (mode_p) begin
            case (state_q)
                IDLE: begin
                    state_d          = HOUR;
                    {num1_d, num2_d} = {bus.cur_hour1, bus.cur_hour2};
                end
                HOUR: begin
                    state_d          = MIN;
                    {num1_d, num2_d} = {bus.cur_min1, bus.cur_min2};
                end
                default: state_d = IDLE;
            endcase
        end else if (state_q != IDLE && (inc_p ^ dec_p)) begin
            {num1_d, num2_d} = step;
        end
        bcnt_d  = (state_d != state_q || state_q == IDLE || bcnt_q == BLINK_LAST) ? '0 : bcnt_q + 1'b1;
        blink_d = (state_d != state_q) ? (state_d != IDLE) :
                  (state_q != IDLE && bcnt_q == BLINK_LAST) ? ~blink_q : blink_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            set_hour_q <= 1'b0;
            set_min_q  <= 1'b0;
            num1_q     <= '0;
            num2_q     <= '0;
            blink_q    <= 1'b0;
            bcnt_q     <= '0;
        end else begin
            state_q    <= state_d;
            set_hour_q <= state_d == HOUR;
            set_min_q  <= state_d == MIN;
            num1_q     <= num1_d;
            num2_q     <= num2_d;
            blink_q    <= blink_d;
            bcnt_q     <= bcnt_d;
        end
    end

    assign bus.set_hour = set_hour_q;
    assign bus.set_min  = set_min_q;
    assign bus.set_num1 = num1_q;
    assign bus.set_num2 = num2_q;
    assign blink        = blink_q;

endmodule

// File: tb/tb_time_set_ctrl.sv
// tb_time_set_ctrl: table-driven button sequences with a queued expected-output scoreboard plus corner-case sequences.
module tb_time_set_ctrl;

    typedef enum logic [2:0] {OP_MODE, OP_INC, OP_DEC, OP_BOTH, OP_MODE_INC} op_e;
    typedef struct {
        op_e        op;
        logic [3:0] ch1, ch2, cm1, cm2;
        logic       sh, sm;
        logic [3:0] n1, n2;
    } vec_t;
    typedef struct {
        logic       sh, sm;
        logic [3:0] n1, n2;
    } exp_t;

    logic clk = 1'b0, rst_n = 1'b0;
    logic btn_mode = 1'b0, btn_inc = 1'b0, btn_dec = 1'b0;
    logic blink;
    logic overlap = 1'b0;
    int   checks = 0, passed = 0, pulses = 0;
    vec_t vecs[28];
    exp_t sbq[$];

    time_set_ctrl_if bus();

    time_set_ctrl #(.DEB_COUNT(4), .BLINK_DIV(8)) dut (
        .clk(clk), .rst_n(rst_n), .btn_mode(btn_mode), .btn_inc(btn_inc),
        .btn_dec(btn_dec), .bus(bus), .blink(blink)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (bus.set_hour && bus.set_min) overlap = 1'b1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (dut.u_inc.pulse_o) pulses++;
    endtask

    task automatic press(input logic m, input logic i, input logic d);
        btn_mode = m; btn_inc = i; btn_dec = d;
        repeat (12) tick();
        btn_mode = 0; btn_inc = 0; btn_dec = 0;
        repeat (12) tick();
    endtask

    task automatic check_outs(input string tag, input logic sh, input logic sm, input logic [3:0] n1, input logic [3:0] n2);
        check({tag, " set_hour"}, bus.set_hour, sh);
        check({tag, " set_min"},  bus.set_min,  sm);
        check({tag, " set_num1"}, bus.set_num1, n1);
        check({tag, " set_num2"}, bus.set_num2, n2);
    endtask

    initial begin
        exp_t       e;
        int         n, first;
        logic [16:0] bl;
        vecs[0]  = '{OP_MODE,     1, 7, 4, 2, 1, 0, 1, 7};
        vecs[1]  = '{OP_INC,      1, 7, 4, 2, 1, 0, 1, 8};
        vecs[2]  = '{OP_INC,      1, 7, 4, 2, 1, 0, 1, 9};
        vecs[3]  = '{OP_INC,      1, 7, 4, 2, 1, 0, 2, 0};
        vecs[4]  = '{OP_DEC,      1, 7, 4, 2, 1, 0, 1, 9};
        vecs[5]  = '{OP_MODE,     1, 7, 4, 2, 0, 1, 4, 2};
        vecs[6]  = '{OP_MODE,     1, 7, 4, 2, 0, 0, 4, 2};
        vecs[7]  = '{OP_INC,      1, 7, 4, 2, 0, 0, 4, 2};
        vecs[8]  = '{OP_MODE,     2, 3, 4, 2, 1, 0, 2, 3};
        vecs[9]  = '{OP_INC,      2, 3, 4, 2, 1, 0, 0, 0};
        vecs[10] = '{OP_DEC,      2, 3, 4, 2, 1, 0, 2, 3};
        vecs[11] = '{OP_DEC,      2, 3, 4, 2, 1, 0, 2, 2};
        vecs[12] = '{OP_MODE,     2, 3, 5, 9, 0, 1, 5, 9};
        vecs[13] = '{OP_INC,      2, 3, 5, 9, 0, 1, 0, 0};
        vecs[14] = '{OP_DEC,      2, 3, 5, 9, 0, 1, 5, 9};
        vecs[15] = '{OP_DEC,      2, 3, 5, 9, 0, 1, 5, 8};
        vecs[16] = '{OP_BOTH,     2, 3, 5, 9, 0, 1, 5, 8};
        vecs[17] = '{OP_MODE,     2, 3, 5, 9, 0, 0, 5, 8};
        vecs[18] = '{OP_MODE,     2, 7, 5, 9, 1, 0, 2, 7};
        vecs[19] = '{OP_INC,      2, 7, 5, 9, 1, 0, 0, 0};
        vecs[20] = '{OP_MODE_INC, 2, 7, 4, 2, 0, 1, 4, 2};
        vecs[21] = '{OP_MODE,     2, 7, 4, 2, 0, 0, 4, 2};
        vecs[22] = '{OP_MODE,     3, 1, 4, 2, 1, 0, 3, 1};
        vecs[23] = '{OP_DEC,      3, 1, 4, 2, 1, 0, 2, 3};
        vecs[24] = '{OP_BOTH,     3, 1, 4, 2, 1, 0, 2, 3};
        vecs[25] = '{OP_MODE,     3, 1, 6, 0, 0, 1, 6, 0};
        vecs[26] = '{OP_DEC,      3, 1, 6, 0, 0, 1, 5, 9};
        vecs[27] = '{OP_MODE,     3, 1, 6, 0, 0, 0, 5, 9};
        {bus.cur_hour1, bus.cur_hour2, bus.cur_min1, bus.cur_min2} = 16'h0000;

        repeat (3) tick();
        check_outs("reset", 0, 0, 0, 0);
        check("reset blink", blink, 0);
        rst_n = 1;
        repeat (2) tick();
        check_outs("post-reset", 0, 0, 0, 0);

        pulses = 0;
        for (int c = 0; c < 5; c++) begin
            btn_inc = 1; repeat (2) tick();
            btn_inc = 0; repeat (2) tick();
        end
        check("bounce no pulse", pulses, 0);
        btn_inc = 1;
        first = 0;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (dut.u_inc.pulse_o && first == 0) first = k;
        end
        check("bounce pulse latency", first, 7);
        btn_inc = 0;
        repeat (12) tick();
        check("bounce pulse count", pulses, 1);
        check_outs("idle ignores inc", 0, 0, 0, 0);

        for (int i = 0; i < 28; i++) begin
            {bus.cur_hour1, bus.cur_hour2, bus.cur_min1, bus.cur_min2} = {vecs[i].ch1, vecs[i].ch2, vecs[i].cm1, vecs[i].cm2};
            sbq.push_back('{vecs[i].sh, vecs[i].sm, vecs[i].n1, vecs[i].n2});
            press(vecs[i].op inside {OP_MODE, OP_MODE_INC},
                  vecs[i].op inside {OP_INC, OP_BOTH, OP_MODE_INC},
                  vecs[i].op inside {OP_DEC, OP_BOTH});
            e = sbq.pop_front();
            check_outs($sformatf("v%0d", i), e.sh, e.sm, e.n1, e.n2);
        end

        check("idle blink", blink, 0);
        {bus.cur_hour1, bus.cur_hour2} = 8'h12;
        btn_mode = 1;
        n = 0;
        while (!bus.set_hour && n < 30) begin tick(); n++; end
        check("mode to set_hour latency", n, 8);
        check("hour entry set_num1", bus.set_num1, 1);
        check("hour entry set_num2", bus.set_num2, 2);
        bl = '0;
        bl[0] = blink;
        for (int k = 1; k <= 16; k++) begin tick(); bl[k] = blink; end
        check("hour blink pattern", bl, 17'h100FF);
        btn_mode = 0;
        repeat (12) tick();
        btn_mode = 1;
        n = 0;
        while (!bus.set_min && n < 30) begin tick(); n++; end
        check("mode to set_min latency", n, 8);
        check("min entry blink", blink, 1);
        check("min entry set_hour", bus.set_hour, 0);
        btn_mode = 0;
        repeat (12) tick();
        btn_mode = 1;
        n = 0;
        while (bus.set_min && n < 30) begin tick(); n++; end
        check("mode to idle latency", n, 8);
        check("idle after min blink", blink, 0);
        btn_mode = 0;
        repeat (12) tick();

        {bus.cur_min1, bus.cur_min2} = 8'h33;
        press(1, 0, 0);
        press(1, 0, 0);
        check_outs("pre-reset min", 0, 1, 3, 3);
        @(posedge clk);
        #3 rst_n = 0;
        #1;
        check_outs("async reset", 0, 0, 0, 0);
        check("async reset blink", blink, 0);
        #20;
        @(negedge clk) rst_n = 1;
        repeat (3) tick();
        check_outs("after reset release", 0, 0, 0, 0);
        {bus.cur_hour1, bus.cur_hour2} = 8'h11;
        press(1, 0, 0);
        check_outs("idle to hour after reset", 1, 0, 1, 1);

        check("set_hour/set_min overlap", overlap, 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/time_set_ctrl.md
# time_set_ctrl

User time-setting front end for the digital clock. Debounces three push-buttons (mode, increment, decrement), walks a mode FSM IDLE → HOUR → MIN → IDLE, and edits a BCD value that it drives onto the counters' set interface (`set_hour`/`set_min` plus `set_num1`/`set_num2`). It sits between the board buttons and the hour/minute BCD counters, and provides a blink flag for the display driver.

## Interface
- `DEB_COUNT`, default 1_000_000: consecutive stable cycles required to accept a button level change (20 ms at 50 MHz).
- `BLINK_DIV`, default 25_000_000: cycles per blink half-period.
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `btn_mode`, `btn_inc`, `btn_dec`  in  1 each  raw asynchronous buttons, active-high.
- `cur_hour1`, `cur_hour2`  in  4 each  live hour tens/ones from the hour counter.
- `cur_min1`, `cur_min2`  in  4 each  live minute tens/ones from the minute counter.
- `set_hour`  out  1  high for the whole HOUR state.
- `set_min`  out  1  high for the whole MIN state.
- `set_num1`, `set_num2`  out  4 each  edited BCD tens/ones.
- `blink`  out  1  display blink enable for the field being edited.

## Operation
- **Reset values:** state IDLE; `set_hour`, `set_min`, `blink` = 0; `set_num1`, `set_num2` = 0; debounced levels = 0; all counters = 0.
- **Button path, per button:**
  - 2-FF synchronizer.
  - Debouncer: a counter counts consecutive cycles where the synced sample ≠ the debounced level. It clears whenever they are equal. On reaching `DEB_COUNT`, the debounced level takes the sample and the counter clears.
  - A one-cycle press pulse is generated on the debounced rising edge. Release generates nothing.
- **FSM transitions** (all registered):
  - IDLE + mode pulse → HOUR; edit regs ← {`cur_hour1`, `cur_hour2`}.
  - HOUR + mode pulse → MIN; edit regs ← {`cur_min1`, `cur_min2`}.
  - MIN + mode pulse → IDLE.
  - In IDLE, inc/dec pulses are ignored.
- **Outputs:** `set_hour` = (state == HOUR) and `set_min` = (state == MIN), both registered. `set_num1`/`set_num2` = edit regs.
- **Hour edit, inc:**
  - 23 → 00.
  - Else ones == 9 → tens+1, ones 0.
  - Else ones+1.
- **Hour edit, dec:**
  - 00 → 23.
  - Else ones == 0 → tens−1, ones 9.
  - Else ones−1.
- **Minute edit:** same rules with a 59 limit (inc 59 → 00, dec 00 → 59).
- **Simultaneous events:**
  - inc and dec pulses in the same cycle: no change.
  - mode with inc/dec in the same cycle: mode wins; inc/dec are discarded. The new field is loaded from the `cur_*` inputs.
- **Out-of-range captured value** (e.g. tens > 2 for hours): the first inc forces 00, the first dec forces the maximum.
- **Blink:**
  - The divider runs only in HOUR/MIN and clears on every state change.
  - `blink` = 1 on entering an edit state and toggles every `BLINK_DIV` cycles.
  - `blink` = 0 in IDLE.
- **Mid-operation reset:** any `rst_n` assertion returns the block to the reset values immediately. There is no set pulse on release.

## Timing
- **Raw edge to press pulse:** 2 sync cycles + `DEB_COUNT` stable cycles + 1 edge-detect cycle. The pulse is exactly one clock wide.
- **Press pulse to state/outputs:** 1 cycle.
  - `set_hour` rises the cycle after the mode pulse, with `set_num` already equal to the captured `cur_hour`. The hour counter therefore reloads its own value and sees no glitch.
  - inc/dec pulse → `set_num` updated 1 cycle later.
- **HOUR → MIN:** `set_hour` falls and `set_min` rises in the same cycle. They are never high together.
- **Level semantics:** the counters load `set_num` every cycle while `set_*` is high; the block relies on that level behaviour.

## Structure
- **Package `clock_pkg`:**
  - state enum (IDLE, HOUR, MIN) in 2-bit encoding;
  - constants HOUR_MAX_T = 2, HOUR_MAX_O = 3, MIN_MAX_T = 5, MIN_MAX_O = 9.
- **Sub-module `btn_debounce`:**
  - synchronizer, debouncer and rising-edge pulse, parameterized by `DEB_COUNT`;
  - instantiated three times.
- **Top level:** FSM, BCD edit logic and blink divider.

## Test plan
All tests use `DEB_COUNT` = 4 and `BLINK_DIV` = 8.
- **Bounce rejection:** toggle `btn_inc` every 2 cycles for 20 cycles, then hold high → exactly one press pulse, 2+4+1 cycles after the final rising edge.
- **Enter edit:** `cur_hour` = 1,7; press mode → `set_hour` = 1 with `set_num` = 1,7. Press inc three times → 2,0. Press dec → 1,9.
- **Hour wrap:** edit at 2,3; inc → 0,0; dec → 2,3. Minute edit at 5,9; inc → 0,0; dec → 5,9.
- **Mode sequencing:** mode ×3 → set_hour-only, then set_min-only (loaded from `cur_min` = 4,2), then both 0. `blink` toggles every 8 cycles in edit states and is 0 in IDLE.
- **Simultaneous events:** inc and dec debounced in the same cycle → value unchanged. mode+inc in the same cycle in HOUR → MIN entered with `cur_min` loaded, no increment applied.
- **Reset mid-edit:** assert `rst_n` low in MIN with `set_num` = 3,3 → all outputs 0 asynchronously, state IDLE after release.
